// File: rtl/rle_pkg.sv
// Shared definitions for the run-length decoder and its matching encoder:
// the default repeat-counter width, the compressed word layout and the
// decoder's two-valued state.
package rle_pkg;

   localparam int RLE_CW = 8;

   typedef struct packed {
      logic [RLE_CW-1:0] cnt;
      logic [7:0]        data;
   } rle_word_t;

   typedef enum logic {
      EMPTY = 1'b0,
      BUSY  = 1'b1
   } rle_state_t;

endpackage

// File: rtl/axi4_stream_if.sv
// Minimal AXI4-Stream bundle. Modport s is the side that sources data,
// modport d is the side that receives it and drives TREADY.
interface axi4_stream_if #(
   parameter type DT = logic [7:0],
   parameter int  DN = 1
);

   logic          TVALID;
   logic          TREADY;
   DT             TDATA;
   logic          TLAST;
   logic [DN-1:0] TKEEP;

   modport s (output TVALID, TDATA, TLAST, TKEEP, input TREADY);
   modport d (input TVALID, TDATA, TLAST, TKEEP, output TREADY);

endinterface

// File: rtl/rle_dec.sv
// Run-length decoder: every compressed word {cnt, data} accepted on sti is
// expanded into cnt+1 copies of data on sto (or a single copy in bypass).
// The output side is a single registered stage; the next word is taken on the
// same edge that retires the last copy of the current one, so consecutive
// words stream without bubbles.
module rle_dec
   import rle_pkg::*;
#(
   parameter int  CW  = RLE_CW,
   parameter int  DN  = 1,
   parameter type DTI = logic [CW+8-1:0],
   parameter type DTO = logic [8-1:0]
) (
   input  logic     ACLK,
   input  logic     ARESET,
   axi4_stream_if.d sti,
   axi4_stream_if.s sto,
   input  logic     ctl_rst,
   input  logic     cfg_ena
);

   rle_state_t    state;
   rle_state_t    state_next;
   logic [CW-1:0] rem;
   logic [CW-1:0] rem_next;
   logic          word_last;
   logic          word_last_next;
   logic          tvalid_q;
   logic          tlast_q;
   logic          tlast_next;
   DTO            data_q;
   DTO            data_next;
   DTI            in_word;
   logic          rem_zero;
   logic          in_fire;
   logic          out_fire;

   assign in_word  = sti.TDATA;
   assign rem_zero = (rem == '0);

   // A new word can enter when nothing is held, or when the beat on the
   // output is the final copy and is being taken this cycle; a soft reset
   // keeps the input open so pending words are drained and dropped.
   assign sti.TREADY = ctl_rst | ~tvalid_q | (sto.TREADY & rem_zero);

   assign in_fire  = sti.TVALID & sti.TREADY;
   assign out_fire = tvalid_q & sto.TREADY;

   assign sto.TVALID = tvalid_q;
   assign sto.TDATA  = data_q;
   assign sto.TLAST  = tlast_q;
   assign sto.TKEEP  = {DN{1'b1}};

   // Next-state decode: flush, load a new word, count down a repeat, or empty.
   always_comb begin
      state_next     = state;
      rem_next       = rem;
      word_last_next = word_last;
      data_next      = data_q;

      if (ctl_rst) begin
         state_next     = EMPTY;
         rem_next       = '0;
         word_last_next = 1'b0;
      end else if (in_fire) begin
         state_next     = BUSY;
         rem_next       = cfg_ena ? in_word[CW+8-1:8] : '0;
         word_last_next = sti.TLAST;
         data_next      = in_word[7:0];
      end else if (out_fire) begin
         if (!rem_zero) begin
            rem_next = rem - CW'(1);
         end else begin
            state_next = EMPTY;
         end
      end

      tlast_next = (state_next == BUSY) & word_last_next & (rem_next == '0);
   end

   // Control state and output qualifiers, cleared asynchronously.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state     <= EMPTY;
         rem       <= '0;
         word_last <= 1'b0;
         tvalid_q  <= 1'b0;
         tlast_q   <= 1'b0;
      end else begin
         state     <= state_next;
         rem       <= rem_next;
         word_last <= word_last_next;
         tvalid_q  <= (state_next == BUSY);
         tlast_q   <= tlast_next;
      end
   end

   // Held data byte; only meaningful while TVALID is high, so it needs no reset.
   always_ff @(posedge ACLK) begin
      data_q <= data_next;
   end

endmodule

// File: tb/tb_rle_dec.sv
// Self-checking bench for rle_dec: directed scenarios followed by randomized
// traffic, all checked against a queue of expected output beats built from
// each accepted compressed word.
module tb_rle_dec;
   import rle_pkg::*;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
   } beat_t;

   logic      clk;
   logic      rst;
   logic      ctl_rst;
   logic      cfg_ena;
   int        checks = 0;
   int        errors = 0;
   int        beats_seen = 0;
   int        lasts_seen = 0;
   bit        rdy_rand = 0;
   beat_t     exp_q[$];
   beat_t     mon_b;
   rle_word_t mon_w;
   int        mon_n;
   logic      stall_held = 0;
   logic [7:0] held_data;
   logic      held_last;

   axi4_stream_if #(.DT(logic [RLE_CW+8-1:0]), .DN(1)) sti_if ();
   axi4_stream_if #(.DT(logic [7:0]), .DN(1)) sto_if ();

   rle_dec #(.CW(RLE_CW), .DN(1)) dut (
      .ACLK    (clk),
      .ARESET  (rst),
      .sti     (sti_if),
      .sto     (sto_if),
      .ctl_rst (ctl_rst),
      .cfg_ena (cfg_ena)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at time %0t", tag, got, want, $time);
      end
   endtask

   // Present one compressed word and hold it until the DUT takes it.
   task automatic applyStimulus(input logic [7:0] cnt, input logic [7:0] data, input logic last);
      int n;
      rle_word_t w;
      w.cnt  = cnt;
      w.data = data;
      sti_if.TDATA  = w;
      sti_if.TLAST  = last;
      sti_if.TVALID = 1'b1;
      n = 0;
      @(negedge clk);
      while (!sti_if.TREADY && n < 2000) begin
         @(negedge clk);
         n++;
      end
      checkOutput("accept", sti_if.TREADY, 1);
      @(posedge clk);
      #1;
      sti_if.TVALID = 1'b0;
   endtask

   // Wait until every expected beat has left the DUT.
   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || sto_if.TVALID) && n < 3000) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("drain_idle", sto_if.TVALID, 0);
      checkOutput("drain_model", exp_q.size(), 0);
   endtask

   // Reference model and scoreboard, sampled mid-cycle where all signals are settled.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         stall_held = 1'b0;
      end else if (ctl_rst) begin
         checkOutput("tready_flush", sti_if.TREADY, 1);
         exp_q.delete();
         stall_held = 1'b0;
      end else begin
         checkOutput("tvalid", sto_if.TVALID, exp_q.size() != 0);
         checkOutput("tready_in", sti_if.TREADY,
                     (!sto_if.TVALID) || (sto_if.TREADY && exp_q.size() == 1));
         checkOutput("tkeep", sto_if.TKEEP, 1);
         if (stall_held) begin
            checkOutput("stall_tvalid", sto_if.TVALID, 1);
            checkOutput("stall_tdata", sto_if.TDATA, held_data);
            checkOutput("stall_tlast", sto_if.TLAST, held_last);
         end
         if (sto_if.TVALID && exp_q.size() != 0) begin
            mon_b = exp_q[0];
            checkOutput("tdata", sto_if.TDATA, mon_b.data);
            checkOutput("tlast", sto_if.TLAST, mon_b.last);
            if (sto_if.TREADY) begin
               exp_q.delete(0);
               beats_seen++;
               if (mon_b.last) lasts_seen++;
            end
         end
         stall_held = sto_if.TVALID && !sto_if.TREADY;
         held_data  = sto_if.TDATA;
         held_last  = sto_if.TLAST;
         if (sti_if.TVALID && sti_if.TREADY) begin
            mon_w = sti_if.TDATA;
            mon_n = cfg_ena ? int'(mon_w.cnt) + 1 : 1;
            for (int i = 0; i < mon_n; i++) begin
               mon_b.data = mon_w.data;
               mon_b.last = sti_if.TLAST && (i == mon_n - 1);
               exp_q.push_back(mon_b);
            end
         end
      end
   end

   // Random back-pressure and enable toggling during the random phase.
   always @(posedge clk) begin
      #1;
      if (rdy_rand) begin
         sto_if.TREADY = ($urandom_range(0, 3) != 0);
         cfg_ena       = $urandom_range(0, 1);
      end
   end

   // Safety net so the run always ends.
   initial begin
      #900000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   // Directed scenarios, random traffic, then asynchronous reset.
   initial begin
      logic stall_pat [5];
      logic [7:0] rcnt;
      stall_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

      rst = 1'b1;
      ctl_rst = 1'b0;
      cfg_ena = 1'b1;
      sti_if.TVALID = 1'b0;
      sti_if.TDATA  = '0;
      sti_if.TLAST  = 1'b0;
      sti_if.TKEEP  = 1'b1;
      sto_if.TREADY = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_tvalid", sto_if.TVALID, 0);
      checkOutput("rst_tlast", sto_if.TLAST, 0);
      checkOutput("rst_tready", sti_if.TREADY, 1);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Four copies of 0xA5, TLAST on the last one.
      beats_seen = 0; lasts_seen = 0;
      applyStimulus(8'd3, 8'hA5, 1'b1);
      drain();
      checkOutput("w_a5_beats", beats_seen, 4);
      checkOutput("w_a5_lasts", lasts_seen, 1);

      // Back-to-back words stream without a bubble.
      beats_seen = 0; lasts_seen = 0;
      applyStimulus(8'd0, 8'h11, 1'b0);
      applyStimulus(8'd0, 8'h22, 1'b0);
      applyStimulus(8'd1, 8'h33, 1'b1);
      drain();
      checkOutput("b2b_beats", beats_seen, 4);
      checkOutput("b2b_lasts", lasts_seen, 1);

      // Largest repeat count.
      beats_seen = 0; lasts_seen = 0;
      applyStimulus(8'd255, 8'h7E, 1'b0);
      drain();
      checkOutput("max_beats", beats_seen, 256);
      checkOutput("max_lasts", lasts_seen, 0);

      // Back-pressure pattern with stalls in the middle of a word.
      beats_seen = 0; lasts_seen = 0;
      applyStimulus(8'd2, 8'h5A, 1'b1);
      for (int i = 0; i < 5; i++) begin
         sto_if.TREADY = stall_pat[i];
         @(posedge clk);
         #1;
      end
      sto_if.TREADY = 1'b1;
      checkOutput("stall_beats", beats_seen, 3);
      drain();

      // Bypass ignores the count.
      beats_seen = 0; lasts_seen = 0;
      cfg_ena = 1'b0;
      applyStimulus(8'd9, 8'hC3, 1'b1);
      drain();
      checkOutput("bypass_beats", beats_seen, 1);
      cfg_ena = 1'b1;

      // Soft reset abandons a partial expansion and drops words offered meanwhile.
      beats_seen = 0; lasts_seen = 0;
      applyStimulus(8'd5, 8'h01, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      ctl_rst = 1'b1;
      sti_if.TDATA  = {8'd3, 8'hEE};
      sti_if.TVALID = 1'b1;
      @(posedge clk); #1;
      ctl_rst = 1'b0;
      sti_if.TVALID = 1'b0;
      checkOutput("flush_tvalid", sto_if.TVALID, 0);
      checkOutput("flush_beats", beats_seen, 2);
      beats_seen = 0;
      applyStimulus(8'd1, 8'h42, 1'b1);
      drain();
      checkOutput("post_flush_beats", beats_seen, 2);

      // Randomized traffic with back-pressure, enable toggling and flushes.
      rdy_rand = 1;
      for (int k = 0; k < 300; k++) begin
         rcnt = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 4));
         if ($urandom_range(0, 15) == 0) begin
            ctl_rst = 1'b1;
            @(posedge clk); #1;
            ctl_rst = 1'b0;
         end
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
         applyStimulus(rcnt, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      end
      drain();
      rdy_rand = 0;
      cfg_ena = 1'b1;

      // Asynchronous reset clears a held final beat without a clock edge.
      sto_if.TREADY = 1'b0;
      applyStimulus(8'd0, 8'h99, 1'b1);
      #2;
      checkOutput("pre_rst_tlast", sto_if.TLAST, 1);
      rst = 1'b1;
      #1;
      checkOutput("async_tvalid", sto_if.TVALID, 0);
      checkOutput("async_tlast", sto_if.TLAST, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      sto_if.TREADY = 1'b1;
      beats_seen = 0;
      applyStimulus(8'd2, 8'h3C, 1'b1);
      drain();
      checkOutput("post_rst_beats", beats_seen, 3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rle_dec.md
RLE_DEC -- requirements
Module: rle_dec

Interface
REQ-001 SHALL have parameter CW, default 8, meaning repeat-counter width.
REQ-002 SHALL have parameter DN, default 1, meaning stream data elements per beat (only 1 supported).
REQ-003 SHALL have parameter DTI, default logic [CW+8-1:0], meaning input word {cnt, data}.
REQ-004 SHALL have parameter DTO, default logic [8-1:0], meaning output data type.
REQ-005 SHALL have port ACLK  input  1  the single clock; all logic is on its rising edge.
REQ-006 SHALL have port ARESET  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port sti  axi4_stream_if.d  DTI  compressed input stream.
REQ-008 SHALL have port sto  axi4_stream_if.s  DTO  expanded output stream.
REQ-009 SHALL have port ctl_rst  input  1  synchronous soft reset, flushes the block.
REQ-010 SHALL have port cfg_ena  input  1  decoding enable; 0 = bypass.

Function
REQ-011 Input word fields SHALL be cnt = TDATA[CW+8-1:8] and data = TDATA[7:0].
REQ-012 With cfg_ena=1, each accepted input word SHALL produce exactly cnt+1 output beats carrying data: cnt=0 gives 1 beat, cnt=2^CW-1 gives 2^CW beats.
REQ-013 With cfg_ena=0, each accepted word SHALL produce exactly 1 output beat carrying data; cnt is ignored.
REQ-014 cfg_ena SHALL be sampled when a word is accepted; a change mid-expansion SHALL NOT affect the word in progress.
REQ-015 Output SHALL be registered: sto.TVALID, sto.TDATA and sto.TLAST come directly from flops.
REQ-016 Latency SHALL be 1 cycle from input transfer to the first output beat becoming valid.
REQ-017 State SHALL be two-valued: EMPTY (sto.TVALID=0) or BUSY (sto.TVALID=1, rem = beats still owed after the current one).
REQ-018 sti.TREADY SHALL equal ~sto.TVALID | (sto.TREADY & rem==0), so back-to-back words stream with no bubble.
REQ-019 On an output transfer with rem!=0, rem SHALL decrement and data SHALL hold.
REQ-020 On an output transfer with rem==0, the block SHALL load the next input word if sti.TVALID; otherwise it SHALL go to EMPTY.
REQ-021 sto.TLAST SHALL be 1 only on the final beat of a word whose input TLAST=1, and 0 on all earlier repeats.
REQ-022 sto.TKEEP SHALL be all ones.
REQ-023 While sto.TREADY=0 in BUSY, all output signals and rem SHALL hold stable (AXI-Stream rule).
REQ-024 The down counter rem SHALL be CW bits wide and SHALL never wrap below 0.

Reset
REQ-025 ARESET=1 SHALL asynchronously force sto.TVALID=0, rem=0, sto.TLAST=0 and state EMPTY.
REQ-026 ctl_rst=1 SHALL, on the next edge, force the same values as ARESET, abandoning any partial expansion.
REQ-027 During ctl_rst=1, sti.TREADY SHALL be 1 and input words SHALL be discarded.
REQ-028 Data registers SHALL need no reset.

Structure
REQ-029 Package rle_pkg SHALL hold the default CW and the typedef of the compressed word {cnt, data}, shared with the encoder.
REQ-030 The design SHALL be a single module with no sub-modules; the counter and holding register are inline.

Verification
REQ-031 Word {cnt=3, data=0xA5, TLAST=1} with sto.TREADY=1 -> four beats of 0xA5 in cycles 1-4, TLAST only on beat 4.
REQ-032 Words {0,0x11},{0,0x22},{1,0x33} presented back-to-back -> output 0x11,0x22,0x33,0x33 on consecutive cycles, and sti.TREADY is 0 only during the first 0x33 beat.
REQ-033 Word {cnt=255, data=0x7E} with CW=8 -> exactly 256 beats, then sto.TVALID falls.
REQ-034 Word {cnt=2, data=0x5A} with sto.TREADY toggling 1,0,0,1,1 -> three 0x5A beats, outputs stable while stalled.
REQ-035 cfg_ena=0, word {cnt=9, data=0xC3} -> single beat 0xC3.
REQ-036 ctl_rst pulsed mid-expansion of {cnt=5, data=0x01} after 2 beats -> sto.TVALID=0 on the next cycle; the next word expands correctly.
